// File: rtl/config_chain_loader_pkg.sv
// Shared types and constants for the configuration-chain loader: FSM encoding,
// CRC-16-CCITT constants and the per-tile chain length.
package config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SET  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MAC tile: 972 interconnect bits + 3 MAC bits.
  localparam int TILE_CHAIN_BITS = 975;

  // Bit-serial CRC-16-CCITT, data bit taken MSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/config_word_serializer.sv
// One-word skid buffer feeding a shift register; emits bits MSB-first and
// accepts a new word straight into the shift register when it is free.
module config_word_serializer
  import config_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_pop,
  output logic              o_buf_full,
  output logic              o_bit_valid,
  output logic              o_bit
);

  localparam int SW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] r_sr;
  logic [WORD_W-1:0] r_buf;
  logic [SW-1:0]     r_sr_cnt;
  logic              r_buf_full;
  logic              w_sr_free;

  // SR can take a word this cycle if it is empty or its last bit is leaving now.
  assign w_sr_free = (r_sr_cnt == '0) || ((r_sr_cnt == SW'(1)) && i_pop);

  // NOTE: state is assigned with <= only, so every reader sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr       <= '0;
      r_buf      <= '0;
      r_sr_cnt   <= '0;
      r_buf_full <= 1'b0;
    end else if (i_flush) begin
      r_sr_cnt   <= '0;
      r_buf_full <= 1'b0;
    end else begin
      if (i_pop) begin
        r_sr     <= r_sr << 1;
        r_sr_cnt <= r_sr_cnt - SW'(1);
      end
      if (w_sr_free) begin
        if (r_buf_full) begin
          r_sr       <= r_buf;
          r_sr_cnt   <= SW'(WORD_W);
          r_buf_full <= 1'b0;
        end else if (i_push) begin
          r_sr     <= i_word;
          r_sr_cnt <= SW'(WORD_W);
        end
      end else if (i_push) begin
        r_buf      <= i_word;
        r_buf_full <= 1'b1;
      end
    end
  end

  assign o_buf_full  = r_buf_full;
  assign o_bit_valid = (r_sr_cnt != '0);
  assign o_bit       = r_sr[WORD_W-1];

endmodule

// File: rtl/config_chain_loader.sv
// Serial configuration-chain loader: host words in, CHAIN_LEN bits out, then a
// cset pulse. Define CONFIG_LOADER_CRC_EN to require a trailing CRC-16 word.
module config_chain_loader
  import config_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int N_TILES     = 1,
  parameter int CHAIN_LEN   = N_TILES * TILE_CHAIN_BITS,
  parameter int CSET_CYCLES = 2,
  parameter int CNT_W       = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_shift,
  output logic              cfg_cen,
  output logic              cfg_cset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef CONFIG_LOADER_CRC_EN
  localparam int WORD_LIMIT = N_WORDS + 1;
`else
  localparam int WORD_LIMIT = N_WORDS;
`endif
  localparam int WC_W = $clog2(WORD_LIMIT + 1);
  localparam int SC_W = (CSET_CYCLES > 1) ? $clog2(CSET_CYCLES) : 1;

  state_t          r_state;
  logic [CNT_W-1:0] r_rem;
  logic [WC_W-1:0] r_wcnt;
  logic [SC_W-1:0] r_set_cnt;
  logic            r_cset;
  logic            r_done;
  logic            r_busy;

  logic w_accept, w_push, w_pop, w_flush;
  logic w_buf_full, w_bit_valid, w_bit;
  logic w_load_end, w_cset_ok;

  assign in_ready = (r_state == ST_LOAD) && !w_buf_full && (r_wcnt < WC_W'(WORD_LIMIT)) && !abort;
  assign w_accept = in_valid && in_ready;
  assign w_pop    = (r_state == ST_LOAD) && w_bit_valid && (r_rem != '0);
  assign w_flush  = (r_state != ST_LOAD) || abort;

`ifdef CONFIG_LOADER_CRC_EN
  logic [15:0] r_crc;
  logic [15:0] r_crc_exp;
  logic        r_crc_got;
  logic        r_err;
  logic        w_is_crc_word;

  assign w_is_crc_word = w_accept && (r_wcnt == WC_W'(N_WORDS));
  assign w_push        = w_accept && !w_is_crc_word;
  assign w_load_end    = (r_rem == '0) && r_crc_got;
  assign w_cset_ok     = (r_crc == r_crc_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc     <= '0;
      r_crc_exp <= '0;
      r_crc_got <= 1'b0;
      r_err     <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_crc     <= CRC_INIT;
      r_crc_got <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_pop) r_crc <= crc16_step(r_crc, w_bit);
      if (w_is_crc_word) begin
        r_crc_exp <= in_data[15:0];
        r_crc_got <= 1'b1;
      end
      if ((r_state == ST_LOAD) && !abort && w_load_end && !w_cset_ok) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_push     = w_accept;
  assign w_load_end = w_pop && (r_rem == CNT_W'(1));
  assign w_cset_ok  = 1'b1;
  assign err        = 1'b0;
`endif

  config_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_word     (in_data),
    .i_pop      (w_pop),
    .o_buf_full (w_buf_full),
    .o_bit_valid(w_bit_valid),
    .o_bit      (w_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_wcnt    <= '0;
      r_set_cnt <= '0;
      r_cset    <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_state <= ST_LOAD;
          r_busy  <= 1'b1;
          r_rem   <= CNT_W'(CHAIN_LEN);
          r_wcnt  <= '0;
        end
        ST_LOAD: if (abort) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end else begin
          if (w_pop)    r_rem  <= r_rem - CNT_W'(1);
          if (w_accept) r_wcnt <= r_wcnt + WC_W'(1);
          if (w_load_end) begin
            r_state   <= ST_SET;
            r_set_cnt <= '0;
            r_cset    <= w_cset_ok;
          end
        end
        ST_SET: if (abort) begin
          r_state <= ST_IDLE;
          r_cset  <= 1'b0;
          r_busy  <= 1'b0;
        end else if (r_set_cnt == SC_W'(CSET_CYCLES - 1)) begin
          r_state <= ST_DONE;
          r_cset  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_set_cnt <= r_set_cnt + SC_W'(1);
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The chain only ever sees data while a bit is actually being shifted.
  assign cfg_cen   = w_pop;
  assign cfg_shift = w_pop && w_bit;
  assign cfg_cset  = r_cset;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboard bench for config_chain_loader with a 40-bit chain and 32-bit words.
module tb_config_chain_loader;

  localparam int WORD_W    = 32;
  localparam int CHAIN_LEN = 40;
  localparam int CSET      = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, cfg_shift, cfg_cen, cfg_cset, busy, done, err;

  config_chain_loader #(
    .WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .CSET_CYCLES(CSET)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_shift(cfg_shift), .cfg_cen(cfg_cen), .cfg_cset(cfg_cset),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cen;
    int cset;
  } done_rec_t;

  logic      exp_bits[$];
  done_rec_t exp_done[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc = 0, cen_load = 0, cset_load = 0, cset_total = 0, done_seen = 0, last_cen_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // Monitor: compares every shifted bit and every completed load against the queues.
  initial begin
    done_rec_t rec;
    logic      b;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (cfg_cen) begin
          if (exp_bits.size() == 0) fail("bit_extra");
          else begin
            b = exp_bits.pop_front();
            check("cfg_shift", cfg_shift, b);
          end
          cen_load++;
          last_cen_cyc = cyc;
        end else begin
          check("shift_zero_no_cen", cfg_shift, 0);
        end
        if (cfg_cset) begin
`ifndef CONFIG_LOADER_CRC_EN
          if (cset_load == 0) check("cset_start", cyc, last_cen_cyc + 1);
`endif
          cset_load++;
          cset_total++;
        end
        if (done) begin
          done_seen++;
          if (exp_done.size() == 0) fail("done_unexpected");
          else begin
            rec = exp_done.pop_front();
            check("cen_cycles", cen_load, rec.cen);
            check("cset_cycles", cset_load, rec.cset);
            check("bits_left", exp_bits.size(), 0);
`ifndef CONFIG_LOADER_CRC_EN
            check("done_latency", cyc, last_cen_cyc + CSET + 1);
`endif
          end
        end
      end
    end
  end

  task automatic clear_mon();
    cen_load  = 0;
    cset_load = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    logic rdy;
    int   budget;
    budget   = 200;
    in_data  = w;
    in_valid = 1'b1;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      budget--;
    end while (!rdy && budget > 0);
    in_valid = 1'b0;
    if (!rdy) fail("send_timeout");
  endtask

  task automatic push_bits(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1);
    for (int i = WORD_W - 1; i >= 0; i--) exp_bits.push_back(w0[i]);
    for (int i = WORD_W - 1; i >= WORD_W - (CHAIN_LEN - WORD_W); i--) exp_bits.push_back(w1[i]);
  endtask

  task automatic run_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                          input int gap, input bit poke, input bit bad);
    done_rec_t rec;
    int        d0, budget;
`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = WORD_W - 1; i >= 0; i--) c = crc_step(c, w0[i]);
    for (int i = WORD_W - 1; i >= WORD_W - (CHAIN_LEN - WORD_W); i--) c = crc_step(c, w1[i]);
`endif
    clear_mon();
    push_bits(w0, w1);
    rec.cen  = CHAIN_LEN;
    rec.cset = bad ? 0 : CSET;
    exp_done.push_back(rec);
    d0 = done_seen;
    do_start();
    check("busy_after_start", busy, 1);
    send_word(w0);
    check("first_cen_latency", cfg_cen, 1);
    if (gap > 0) begin
      budget = 100;
      while (cen_load < WORD_W && budget > 0) begin
        @(posedge clk); #1;
        budget--;
      end
      if (budget == 0) fail("gap_drain_timeout");
      for (int i = 0; i < gap; i++) begin
        check("gap_cen_low", cfg_cen, 0);
        if (i < gap - 1) begin
          @(posedge clk); #1;
        end
      end
      send_word(w1);
      check("gap_resume", cfg_cen, 1);
    end else begin
      send_word(w1);
    end
`ifdef CONFIG_LOADER_CRC_EN
    send_word({16'h0000, c ^ (bad ? 16'h0001 : 16'h0000)});
`endif
    check("ready_after_last_word", in_ready, 0);
    if (poke) begin
      repeat (3) begin
        @(posedge clk); #1;
      end
      do_start();
      budget = 100;
      while (!cfg_cset && budget > 0) begin
        @(posedge clk); #1;
        budget--;
      end
      if (budget == 0) fail("cset_wait_timeout");
      do_start();
    end
    budget = 300;
    while (done_seen == d0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) fail("done_timeout");
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("single_done", done_seen - d0, 1);
    check("busy_after_done", busy, 0);
    check("err_flag", err, bad);
  endtask

  initial begin
    int d0, c0, budget;

    #2;
    check("rst_cen", cfg_cen, 0);
    check("rst_cset", cfg_cset, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", in_ready, 0);
    check("idle_busy", busy, 0);

    run_load(32'hA500_0001, 32'hC3FF_FFFF, 0, 1'b0, 1'b0);
    run_load(32'hA500_0001, 32'hC3FF_FFFF, 5, 1'b0, 1'b0);
    run_load(32'h0F0F_1234, 32'h5A00_0000, 0, 1'b0, 1'b0);

    // Abort on the 20th shifted bit.
    clear_mon();
    push_bits(32'hA500_0001, 32'hC3FF_FFFF);
    d0 = done_seen;
    c0 = cset_total;
    do_start();
    send_word(32'hA500_0001);
    send_word(32'hC3FF_FFFF);
    budget = 100;
    while (!(cen_load == 19 && cfg_cen) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) fail("abort_wait_timeout");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_cen", cfg_cen, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 0);
    check("abort_bits_shifted", cen_load, 20);
    exp_bits.delete();
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("abort_no_done", done_seen - d0, 0);
    check("abort_no_cset", cset_total - c0, 0);
    run_load(32'hA500_0001, 32'hC3FF_FFFF, 0, 1'b0, 1'b0);

    // start pulses while busy must be ignored.
    run_load(32'hA500_0001, 32'hC3FF_FFFF, 0, 1'b1, 1'b0);

    // Asynchronous reset between edges in the middle of a shift.
    clear_mon();
    push_bits(32'hA500_0001, 32'hC3FF_FFFF);
    do_start();
    send_word(32'hA500_0001);
    repeat (10) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_cen", cfg_cen, 0);
    check("arst_shift", cfg_shift, 0);
    check("arst_cset", cfg_cset, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ready", in_ready, 0);
    exp_bits.delete();
    exp_done.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 0);
    check("post_rst_busy", busy, 0);
    run_load(32'hA500_0001, 32'hC3FF_FFFF, 0, 1'b0, 1'b0);

`ifdef CONFIG_LOADER_CRC_EN
    run_load(32'hA500_0001, 32'hC3FF_FFFF, 0, 1'b0, 1'b1);
    run_load(32'h0F0F_1234, 32'h5A00_0000, 0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
